// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-and-add-3 (double-dabble) binary to BCD
// converter. It converts one input bit per clock and holds the three result
// digits stable between conversions, so the display mux never sees partial
// values.
// Optional build macro BCD_SIGNED_EN: treats bin as two's complement, converts
// its magnitude, and adds the registered sign output Neg.
module bin_to_bcd_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       Ones,
  output logic [3:0]       Tens,
  output logic [3:0]       Hundreds
`ifdef BCD_SIGNED_EN
  ,
  output logic             Neg
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The counter reaches WIDTH-1 on the final shift step.
  localparam logic [3:0] LAST_CNT = 4'(WIDTH - 1);

  state_t           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [11:0]      scratch_r;
  logic [3:0]       cnt_r;
  logic [WIDTH-1:0] load_s;
  logic [11:0]      adj_s;
`ifdef BCD_SIGNED_EN
  logic             neg_cap_r;
`endif

  // A BCD nibble of 5 or more would overflow past 9 when doubled, so add 3 first.
  function automatic logic [3:0] add3_adjust(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

  // Adjust all three scratch nibbles independently. Carries never cross nibbles.
  always_comb begin
    adj_s = {add3_adjust(scratch_r[11:8]),
             add3_adjust(scratch_r[7:4]),
             add3_adjust(scratch_r[3:0])};
  end

  // Value loaded into the shift register. In signed mode it is the magnitude,
  // and the most negative input wraps to its full unsigned magnitude.
  always_comb begin
    load_s = bin;
`ifdef BCD_SIGNED_EN
    if (bin[WIDTH-1]) begin
      load_s = {WIDTH{1'b0}} - bin;
    end else begin
      load_s = bin;
    end
`endif
  end

  // busy is a pure decode of the state register.
  always_comb begin
    if (state_r != IDLE) begin
      busy = 1'b1;
    end else begin
      busy = 1'b0;
    end
  end

  // Conversion FSM with registered digit, sign and done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      shreg_r   <= {WIDTH{1'b0}};
      scratch_r <= 12'd0;
      cnt_r     <= 4'd0;
      done      <= 1'b0;
      Ones      <= 4'd0;
      Tens      <= 4'd0;
      Hundreds  <= 4'd0;
`ifdef BCD_SIGNED_EN
      neg_cap_r <= 1'b0;
      Neg       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            shreg_r   <= load_s;
            scratch_r <= 12'd0;
            cnt_r     <= 4'd0;
`ifdef BCD_SIGNED_EN
            neg_cap_r <= bin[WIDTH-1];
`endif
            state_r   <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          // Shift {scratch, shreg} left by one. The shreg MSB enters the scratch LSB.
          scratch_r <= 12'({adj_s, shreg_r[WIDTH-1]});
          shreg_r   <= {shreg_r[WIDTH-2:0], 1'b0};
          cnt_r     <= cnt_r + 4'd1;
          if (cnt_r == LAST_CNT) begin
            state_r <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          Ones     <= scratch_r[3:0];
          Tens     <= scratch_r[7:4];
          Hundreds <= scratch_r[11:8];
`ifdef BCD_SIGNED_EN
          Neg      <= neg_cap_r;
`endif
          done     <= 1'b1;
          state_r  <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq (WIDTH = 8). It uses a directed vector table,
// random vectors checked against an arithmetic decimal model, and hand-written
// sequences for multi-cycle corner cases. It follows BCD_SIGNED_EN when defined.
module tb_bin_to_bcd_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] bin;
  logic         busy;
  logic         done;
  logic [3:0]   Ones;
  logic [3:0]   Tens;
  logic [3:0]   Hundreds;
`ifdef BCD_SIGNED_EN
  logic         Neg;
`endif

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [7:0] bin;
    logic       neg;
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
  } vec_t;

  vec_t tbl[9];

  bin_to_bcd_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .Ones     (Ones),
    .Tens     (Tens),
    .Hundreds (Hundreds)
`ifdef BCD_SIGNED_EN
    ,
    .Neg      (Neg)
`endif
  );

  // Free-running clock with a 10-time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: decimal digits computed with plain arithmetic, and the
  // magnitude taken from the signed reading when the signed build is enabled.
  function automatic logic [12:0] model(input logic [7:0] v);
    int   m;
    logic neg;
`ifdef BCD_SIGNED_EN
    neg = v[7];
    if (neg) m = 256 - int'(v);
    else     m = int'(v);
`else
    neg = 1'b0;
    m   = int'(v);
`endif
    return {neg, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic check_digits(input string name, input logic [12:0] e);
    check({name, " hundreds"}, int'(Hundreds), int'(e[11:8]));
    check({name, " tens"},     int'(Tens),     int'(e[7:4]));
    check({name, " ones"},     int'(Ones),     int'(e[3:0]));
`ifdef BCD_SIGNED_EN
    check({name, " neg"},      int'(Neg),      int'(e[12]));
`endif
  endtask

  // Runs one conversion. It checks busy, latency, the result and digit hold.
  task automatic run_conv(input string name, input logic [7:0] v, input logic [12:0] e);
    int   n;
    logic busy_bad;
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin   = ~v;
    n        = 0;
    busy_bad = 1'b0;
    while (!done && n < 30) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, n, W + 1);
    check({name, " busy during conv"}, int'(busy_bad), 0);
    check({name, " busy at done"}, int'(busy), 0);
    check_digits(name, e);
    repeat (3) @(negedge clk);
    check({name, " done one cycle"}, int'(done), 0);
    check_digits({name, " hold"}, e);
  endtask

  initial begin
    int          n;
    int          dones;
    logic [7:0]  rv;
    logic [12:0] e;

    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    bin          = 8'd0;

`ifdef BCD_SIGNED_EN
    tbl[0] = '{8'h80, 1'b1, 4'd1, 4'd2, 4'd8};
    tbl[1] = '{8'hFF, 1'b1, 4'd0, 4'd0, 4'd1};
    tbl[2] = '{8'd127, 1'b0, 4'd1, 4'd2, 4'd7};
    tbl[3] = '{8'd0,  1'b0, 4'd0, 4'd0, 4'd0};
    tbl[4] = '{8'd9,  1'b0, 4'd0, 4'd0, 4'd9};
    tbl[5] = '{8'h9C, 1'b1, 4'd1, 4'd0, 4'd0};
    tbl[6] = '{8'd99, 1'b0, 4'd0, 4'd9, 4'd9};
    tbl[7] = '{8'hF6, 1'b1, 4'd0, 4'd1, 4'd0};
    tbl[8] = '{8'd123, 1'b0, 4'd1, 4'd2, 4'd3};
`else
    tbl[0] = '{8'd255, 1'b0, 4'd2, 4'd5, 4'd5};
    tbl[1] = '{8'd0,   1'b0, 4'd0, 4'd0, 4'd0};
    tbl[2] = '{8'd9,   1'b0, 4'd0, 4'd0, 4'd9};
    tbl[3] = '{8'd123, 1'b0, 4'd1, 4'd2, 4'd3};
    tbl[4] = '{8'd200, 1'b0, 4'd2, 4'd0, 4'd0};
    tbl[5] = '{8'd7,   1'b0, 4'd0, 4'd0, 4'd7};
    tbl[6] = '{8'd100, 1'b0, 4'd1, 4'd0, 4'd0};
    tbl[7] = '{8'd99,  1'b0, 4'd0, 4'd9, 4'd9};
    tbl[8] = '{8'd10,  1'b0, 4'd0, 4'd1, 4'd0};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check_digits("reset", 13'd0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      run_conv($sformatf("tbl%0d", i), tbl[i].bin,
               {tbl[i].neg, tbl[i].h, tbl[i].t, tbl[i].o});
    end

    // Random vectors against the model
    for (int i = 0; i < 30; i++) begin
      rv = 8'($urandom_range(0, 255));
      run_conv($sformatf("rand%0d", i), rv, model(rv));
    end

    // A start while busy is ignored: only one done, with the first value.
    @(negedge clk);
    bin = 8'd123; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    bin = 8'd45; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        dones++;
        if (dones == 1) check_digits("ignored start", model(8'd123));
      end
      @(negedge clk);
    end
    check("ignored start done count", dones, 1);

    // Start re-asserted in the done cycle: done pulses are exactly 10 cycles apart.
    @(negedge clk);
    bin = 8'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("b2b first latency", n, W + 1);
    check_digits("b2b first", model(8'd200));
    bin = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("b2b spacing", n, W + 2);
    check_digits("b2b second", model(8'd7));

    // Reset mid-conversion aborts asynchronously, with no done afterwards.
    @(negedge clk);
    bin = 8'd250; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset busy", int'(busy), 0);
    check("mid reset done", int'(done), 0);
    check_digits("mid reset", 13'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 15; c++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("mid reset no done", dones, 0);
    check_digits("mid reset hold", 13'd0);
    run_conv("after reset", 8'd58, model(8'd58));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential shift-and-add-3 (double-dabble) converter.
- Turns a registered binary ALU result into three BCD digits: Ones, Tens, Hundreds.
- Sits directly upstream of the display digit mux and drives its Ones/Tens/Hundreds inputs.
- Converts one bit per clock. Results are held stable between conversions so the display scan never sees partial digits.

Parameters:
- WIDTH, 8, binary input width. Legal range 4..9; 3 BCD digits cover 0..511.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a conversion of bin; sampled on rising clk edge
- bin  input  WIDTH  binary value; captured only on the accepted start edge
- busy  output  1  high while a conversion is in progress (state != IDLE)
- done  output  1  one-cycle pulse; Ones/Tens/Hundreds updated in the same cycle
- Ones  output  4  BCD units digit, registered
- Tens  output  4  BCD tens digit, registered
- Hundreds  output  4  BCD hundreds digit, registered

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE, busy = 0, done = 0.
  - Ones = Tens = Hundreds = 0.
  - Internal shift register, scratch BCD (12 bits) and bit counter all cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - At edge k with start = 1: capture bin into the shift register, clear scratch, cnt = 0, go to SHIFT.
  - start = 0: stay in IDLE.
- SHIFT, one step per edge:
  - Each scratch nibble >= 5 gets +3 (4-bit add, no carry into the next nibble).
  - Then shift {scratch, shreg} left by 1; shreg MSB enters the scratch LSB.
  - cnt increments. On the step where cnt == WIDTH-1, go to DONE.
  - Exactly WIDTH SHIFT cycles.
- DONE, at edge k+WIDTH+1:
  - Copy scratch nibbles to Ones/Tens/Hundreds, set done = 1, go to IDLE.
- Latency: start sampled at edge k -> done high and digits valid during the cycle after edge k+WIDTH+1. For WIDTH = 8 that is edge k+9.
- busy: combinational decode of state. High from after edge k until after edge k+WIDTH+1.
- done: registered. Cleared on every edge where DONE is not being entered, so it is exactly one cycle wide.
- Output hold: Ones/Tens/Hundreds change only on the DONE edge (or reset). They hold the last result indefinitely.
- start while busy = 1: ignored, no queuing. bin changes during a conversion have no effect.
- start high in the done cycle: accepted, since state is IDLE. Back-to-back conversions every WIDTH+2 cycles.
- start held high continuously: converts repeatedly, one conversion per WIDTH+2 cycles.
- Reset mid-conversion: aborts immediately, all outputs return to reset values, no done pulse.
- Arithmetic: the scratch width is fixed at 12 bits. The top nibble never exceeds 5 for WIDTH <= 9, so no overflow handling is required.

Optional Feature:
- Macro: BCD_SIGNED_EN
- Defined:
  - bin is two's complement.
  - Adds output port Neg (1 bit, registered, reset 0). Neg = bin MSB captured at start and updated on the DONE edge alongside the digits.
  - The magnitude (-bin if negative, else bin) is converted. The most negative value -2^(WIDTH-1) converts to its full magnitude.
  - Latency is unchanged; negation happens on the load edge.
- Undefined:
  - bin is unsigned, the Neg port does not exist, and no negation logic is generated.

Test Plan:
- WIDTH=8, bin=8'd255, start pulse at edge k -> busy high edges k..k+9; done pulse after edge k+9; Hundreds=2, Tens=5, Ones=5.
- bin=0 and then bin=8'd9, sequential conversions -> 0/0/0, then 0/0/9; digits unchanged between done pulses.
- start at k (bin=8'd123); start again at k+3 with bin=8'd45 -> second start ignored; single done with 1/2/3.
- start re-asserted in the done cycle (bin=8'd200 then 8'd7) -> two done pulses exactly 10 cycles apart; results 2/0/0 then 0/0/7.
- rst_n low at edge k+4 mid-conversion -> busy=0 and done=0 immediately (asynchronously); digits 0/0/0; no done pulse; a new start after release converts correctly.
- BCD_SIGNED_EN defined, WIDTH=8: bin=8'h80 -> Neg=1, 1/2/8; bin=8'hFF -> Neg=1, 0/0/1; bin=8'd127 -> Neg=0, 1/2/7.
